// File: rtl/seq_magnitude_comp.sv
// Multi-cycle MSB-first magnitude comparator with start/busy/done handshake.
// Define SIGNED_CMP_EN to add the signed_mode port for two's-complement compares.
module seq_magnitude_comp #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SIGNED_CMP_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             A_great_B,
  output logic             A_equal_B,
  output logic             A_less_B
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             busy_n, done_n, great_n, equal_n, less_n;
  logic             load, shift;
  logic [DIGIT-1:0] a_cmp, b_cmp;
`ifdef SIGNED_CMP_EN
  logic             sm_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      A_great_B <= 1'b0;
      A_equal_B <= 1'b0;
      A_less_B  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      busy      <= busy_n;
      done      <= done_n;
      A_great_B <= great_n;
      A_equal_B <= equal_n;
      A_less_B  <= less_n;
    end
  end

  // Operands shift left so the slice under test always sits at the top.
  always_ff @(posedge clk) begin
    if (load) begin
      a_sh <= A;
      b_sh <= B;
`ifdef SIGNED_CMP_EN
      sm_reg <= signed_mode;
`endif
    end else if (shift) begin
      a_sh <= a_sh << DIGIT;
      b_sh <= b_sh << DIGIT;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    busy_n  = busy;
    done_n  = 1'b0;
    great_n = A_great_B;
    equal_n = A_equal_B;
    less_n  = A_less_B;
    load    = 1'b0;
    shift   = 1'b0;
    a_cmp   = a_sh[WIDTH-1 -: DIGIT];
    b_cmp   = b_sh[WIDTH-1 -: DIGIT];
`ifdef SIGNED_CMP_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    if (sm_reg && (idx == '0)) begin
      a_cmp[DIGIT-1] = ~a_cmp[DIGIT-1];
      b_cmp[DIGIT-1] = ~b_cmp[DIGIT-1];
    end
`endif
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          idx_n   = '0;
          busy_n  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (a_cmp != b_cmp) begin
          great_n = (a_cmp > b_cmp);
          less_n  = (a_cmp < b_cmp);
          equal_n = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (idx == LAST_IDX) begin
          great_n = 1'b0;
          less_n  = 1'b0;
          equal_n = 1'b1;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          idx_n = idx + IDX_W'(1);
          shift = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
